// File: rtl/oled_spi_sink_if.sv
// Received-byte stream between the OLED SPI sink and its consumer.
// The master drives valid/data/dc, and the slave answers with ready.
interface oled_spi_sink_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, output rx_dc, input rx_ready);
    modport slave  (input rx_valid, input rx_data, input rx_dc, output rx_ready);
endinterface

// File: rtl/oled_spi_sink.sv
// Oversampling receiver for the 4-wire OLED SPI link (mode 0, MSB first).
// Rebuilt bytes, tagged with D/C, leave on a valid/ready stream with frame accounting.
module oled_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 1024,
    localparam int CNT_W      = $clog2(FRAME_BYTES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_dc,
    input  logic              spi_cs_n,
    input  logic              spi_res_n,
    input  logic              clr_overrun,
    oled_spi_sink_if.master   rx,
    output logic [CNT_W-1:0]  byte_count,
    output logic              frame_done,
    output logic              overrun
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    logic [4:0]       sync_r [SYNC_STAGES];
    logic             sclk_prev_r;
    logic             sclk_s, mosi_s, dc_s, cs_n_s, res_n_s, sclk_rise_s;
    state_t           state_r, state_nxt_s;
    logic             shift_en_s, complete_s, transfer_s;
    logic [6:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       new_byte_s;
    logic             hold_valid_r, hold_dc_r, frame_done_r, overrun_r;
    logic [7:0]       hold_data_r;
    logic [CNT_W-1:0] byte_count_r;

    // Synchronizer chain shared by all five link inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 5'b00000;
            end
            sclk_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {spi_clk, spi_mosi, spi_dc, spi_cs_n, spi_res_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            sclk_prev_r <= sclk_s;
        end
    end

    assign sclk_s      = sync_r[SYNC_STAGES-1][4];
    assign mosi_s      = sync_r[SYNC_STAGES-1][3];
    assign dc_s        = sync_r[SYNC_STAGES-1][2];
    assign cs_n_s      = sync_r[SYNC_STAGES-1][1];
    assign res_n_s     = sync_r[SYNC_STAGES-1][0];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;

    // Link state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state; shifting is allowed only while the link stays selected and out of reset
    always_comb begin
        state_nxt_s = ST_IDLE;
        shift_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!cs_n_s && res_n_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!cs_n_s && res_n_s) begin
                    state_nxt_s = ST_SHIFT;
                    shift_en_s  = sclk_rise_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign complete_s = shift_en_s && (bit_cnt_r == 3'd7);
    assign new_byte_s = {shift_r, mosi_s};
    assign transfer_s = hold_valid_r && rx.rx_ready;

    // Bit assembly; leaving SHIFT throws away any partial byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_r   <= 7'd0;
            bit_cnt_r <= 3'd0;
        end else if (state_nxt_s == ST_IDLE) begin
            shift_r   <= 7'd0;
            bit_cnt_r <= 3'd0;
        end else if (shift_en_s) begin
            shift_r   <= new_byte_s[6:0];
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Holding register: a completed byte may replace one leaving in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
            hold_dc_r    <= 1'b0;
        end else if (complete_s && (!hold_valid_r || rx.rx_ready)) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= new_byte_s;
            hold_dc_r    <= dc_s;
        end else if (transfer_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    // Sticky overrun; a new drop outranks a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (complete_s && hold_valid_r && !rx.rx_ready) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Frame position; a command byte or a display reset realigns to the frame start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_count_r <= '0;
            frame_done_r <= 1'b0;
        end else if (!res_n_s) begin
            byte_count_r <= '0;
            frame_done_r <= 1'b0;
        end else if (transfer_s && hold_dc_r && (byte_count_r == LAST_IDX)) begin
            byte_count_r <= '0;
            frame_done_r <= 1'b1;
        end else if (transfer_s && hold_dc_r) begin
            byte_count_r <= byte_count_r + CNT_W'(1);
            frame_done_r <= 1'b0;
        end else if (transfer_s) begin
            byte_count_r <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
        end
    end

    assign rx.rx_valid = hold_valid_r;
    assign rx.rx_data  = hold_data_r;
    assign rx.rx_dc    = hold_dc_r;
    assign byte_count  = byte_count_r;
    assign frame_done  = frame_done_r;
    assign overrun     = overrun_r;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink (FRAME_BYTES = 4): queued expected bytes are
// compared as the sink hands them over, and frame and overrun behaviour is checked between steps.
module tb_oled_spi_sink;
    logic       clock = 1'b0;
    logic       reset;
    logic       spi_clk, spi_mosi, spi_dc, spi_cs_n, spi_res_n, clr_overrun;
    logic [1:0] byte_count;
    logic       frame_done, overrun;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         xfer_cnt = 0;
    int         push_cnt = 0;
    int         valid_cycles = 0;
    int         fd_cnt = 0;
    logic [8:0] sb_q [$];

    oled_spi_sink_if rx();

    oled_spi_sink #(.SYNC_STAGES(2), .FRAME_BYTES(4)) dut (
        .clock(clock), .reset(reset),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
        .spi_cs_n(spi_cs_n), .spi_res_n(spi_res_n),
        .clr_overrun(clr_overrun), .rx(rx.master),
        .byte_count(byte_count), .frame_done(frame_done), .overrun(overrun)
    );

    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic dc);
        spi_mosi = b;
        spi_dc   = dc;
        tick(4);
        spi_clk = 1'b1;
        tick(4);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic dc);
        for (int i = 7; i >= 0; i--) send_bit(data[i], dc);
    endtask

    task automatic push(input logic [7:0] data, input logic dc);
        sb_q.push_back({dc, data});
        push_cnt++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, rx.rx_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, rx.rx_data}, 32'd0);
        check({tag, "_dc"}, {31'd0, rx.rx_dc}, 32'd0);
        check({tag, "_count"}, {30'd0, byte_count}, 32'd0);
        check({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    // Scoreboard and event counters sampled on the falling edge
    always @(negedge clock) begin
        if (!reset) begin
            if (rx.rx_valid) valid_cycles++;
            if (frame_done) fd_cnt++;
            if (rx.rx_valid && rx.rx_ready) begin
                xfer_cnt++;
                check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    check("sb_byte", {23'd0, rx.rx_dc, rx.rx_data}, {23'd0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, x0, f0;
        reset = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
        spi_cs_n = 1'b1; spi_res_n = 1'b1; clr_overrun = 1'b0; rx.rx_ready = 1'b0;
        tick(5);
        check_outputs_zero("rst");
        reset = 1'b0;
        tick(4);

        // Single data byte with consumer ready: one valid cycle, count 1
        spi_cs_n = 1'b0; rx.rx_ready = 1'b1;
        tick(2);
        v0 = valid_cycles;
        push(8'hA5, 1'b1);
        send_byte(8'hA5, 1'b1);
        tick(6);
        check("a5_valid_cycles", valid_cycles - v0, 32'd1);
        check("a5_count", {30'd0, byte_count}, 32'd1);

        // Reset mid-byte with a byte held: everything clears without waiting for a clock
        rx.rx_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        tick(6);
        check("held_valid", {31'd0, rx.rx_valid}, 32'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        reset = 1'b1; spi_cs_n = 1'b1;
        #1;
        check_outputs_zero("midrst");
        tick(3);
        reset = 1'b0;
        tick(4);
        spi_cs_n = 1'b0; rx.rx_ready = 1'b1;
        tick(2);
        push(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        tick(6);
        check("5a_count", {30'd0, byte_count}, 32'd1);

        // Consumer stalled: second byte dropped, first held, overrun raised then cleared
        rx.rx_ready = 1'b0;
        push(8'h3C, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b0);
        tick(6);
        check("ovr_valid", {31'd0, rx.rx_valid}, 32'd1);
        check("ovr_data", {24'd0, rx.rx_data}, 32'h3C);
        check("ovr_dc", {31'd0, rx.rx_dc}, 32'd1);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        tick(1);
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        check("ovr_data_kept", {24'd0, rx.rx_data}, 32'h3C);
        rx.rx_ready = 1'b1;
        tick(3);
        check("3c_count", {30'd0, byte_count}, 32'd2);

        // Partial byte aborted by chip select: only the following byte appears
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        spi_cs_n = 1'b1;
        tick(6);
        spi_cs_n = 1'b0;
        tick(2);
        push(8'h81, 1'b1);
        send_byte(8'h81, 1'b1);
        tick(6);
        check("abort_xfers", xfer_cnt - x0, 32'd1);
        check("abort_ovr", {31'd0, overrun}, 32'd0);
        check("abort_count", {30'd0, byte_count}, 32'd3);

        // Frame accounting: command realigns, fourth data byte wraps with frame_done
        push(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        tick(6);
        check("cmd_count", {30'd0, byte_count}, 32'd0);
        f0 = fd_cnt;
        for (int k = 0; k < 3; k++) begin
            push(8'h10 + 8'(k), 1'b1);
            send_byte(8'h10 + 8'(k), 1'b1);
        end
        tick(6);
        check("frame3_count", {30'd0, byte_count}, 32'd3);
        check("frame3_fdone", fd_cnt - f0, 32'd0);
        push(8'hF0, 1'b1);
        send_byte(8'hF0, 1'b1);
        tick(6);
        check("frame4_count", {30'd0, byte_count}, 32'd0);
        check("frame4_fdone", fd_cnt - f0, 32'd1);
        f0 = fd_cnt;
        push(8'h21, 1'b1); send_byte(8'h21, 1'b1);
        push(8'h22, 1'b1); send_byte(8'h22, 1'b1);
        tick(6);
        check("mid_count", {30'd0, byte_count}, 32'd2);
        push(8'hAF, 1'b0); send_byte(8'hAF, 1'b0);
        tick(6);
        check("realign_count", {30'd0, byte_count}, 32'd0);
        check("realign_fdone", fd_cnt - f0, 32'd0);

        // Display reset clears the count but the held byte survives
        push(8'h31, 1'b1); send_byte(8'h31, 1'b1);
        push(8'h32, 1'b1); send_byte(8'h32, 1'b1);
        tick(6);
        check("pre_res_count", {30'd0, byte_count}, 32'd2);
        rx.rx_ready = 1'b0;
        push(8'hE7, 1'b1);
        send_byte(8'hE7, 1'b1);
        tick(6);
        spi_res_n = 1'b0;
        tick(6);
        check("res_count", {30'd0, byte_count}, 32'd0);
        spi_res_n = 1'b1;
        tick(4);
        check("res_valid", {31'd0, rx.rx_valid}, 32'd1);
        check("res_data", {24'd0, rx.rx_data}, 32'hE7);
        x0 = xfer_cnt;
        rx.rx_ready = 1'b1;
        tick(3);
        check("res_xfer", xfer_cnt - x0, 32'd1);
        check("res_after_count", {30'd0, byte_count}, 32'd1);

        check("sb_drained", sb_q.size(), 32'd0);
        check("xfer_total", xfer_cnt, push_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
